// File: rtl/gate_truth_checker.sv
// Purpose : walks every input combination of an N_IN-input gate, samples its
//           response and scores it against a programmed truth table.
// Latency : result (done/pass) valid SETTLE*2**N_IN cycles after the start edge.
// Backpressure: none; start is ignored while a run is in progress.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin a run (accepted in IDLE or DONE only)
//   truth        expected response, bit k for dut_in == k (latched at start)
//   dut_out      response of the gate under test
//   dut_in       combination currently driven to the gate
//   busy, done   run in progress / run finished (results held)
//   pass         done with zero mismatches
//   err_count    mismatching combinations in the current/last run
//   fail_valid   at least one mismatch seen; first_fail holds the lowest one
module gate_truth_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   truth,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail
);

  localparam int              NCOMB         = 1 << N_IN;
  localparam logic [3:0]      SETTLE_RELOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_COMB     = '1;
  localparam logic [N_IN-1:0] COMB_STEP     = N_IN'(1);
  localparam logic [N_IN:0]   ERR_STEP      = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [NCOMB-1:0]    truth_q, truth_nx;
  logic [3:0]          settle_cnt, settle_nx;
  logic [N_IN-1:0]     dut_in_nx;
  logic                busy_nx, done_nx, pass_nx;
  logic [N_IN:0]       err_nx;
  logic                fail_valid_nx;
  logic [N_IN-1:0]     first_fail_nx;

  logic                mismatch;
  logic [N_IN:0]       err_upd;

  // Score of the current combination; err_upd already folds in this edge's
  // mismatch so the final pass flag sees the last sample too.
  assign mismatch = (dut_out != truth_q[dut_in]);
  assign err_upd  = mismatch ? (err_count + ERR_STEP) : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      truth_q    <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      state      <= state_nx;
      truth_q    <= truth_nx;
      settle_cnt <= settle_nx;
      dut_in     <= dut_in_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      err_count  <= err_nx;
      fail_valid <= fail_valid_nx;
      first_fail <= first_fail_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    truth_nx      = truth_q;
    settle_nx     = settle_cnt;
    dut_in_nx     = dut_in;
    busy_nx       = busy;
    done_nx       = done;
    pass_nx       = pass;
    err_nx        = err_count;
    fail_valid_nx = fail_valid;
    first_fail_nx = first_fail;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx      = S_RUN;
          truth_nx      = truth;
          settle_nx     = SETTLE_RELOAD;
          dut_in_nx     = '0;
          busy_nx       = 1'b1;
          done_nx       = 1'b0;
          pass_nx       = 1'b0;
          err_nx        = '0;
          fail_valid_nx = 1'b0;
          first_fail_nx = '0;
        end
      end

      S_RUN: begin
        if (settle_cnt != 4'd0) begin
          settle_nx = settle_cnt - 4'd1;
        end else begin
          // Sample edge: dut_in has been stable for the whole settle window.
          err_nx = err_upd;
          if (mismatch && !fail_valid) begin
            fail_valid_nx = 1'b1;
            first_fail_nx = dut_in;
          end
          if (dut_in == LAST_COMB) begin
            state_nx  = S_DONE;
            busy_nx   = 1'b0;
            done_nx   = 1'b1;
            dut_in_nx = '0;
            pass_nx   = (err_upd == '0);
          end else begin
            dut_in_nx = dut_in + COMB_STEP;
            settle_nx = SETTLE_RELOAD;
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE=1 and SETTLE=3, N_IN=2)
// share start/truth and drive behavioural gates described by a 4-entry table.
// A run-level model predicts every output from elapsed cycles since start.
module tb_gate_truth_checker;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] truth = 4'b1110;
  bit   [3:0] gt    = 4'b1110;   // table of the gate currently being checked

  logic [1:0] s1_din, s3_din, s1_ff, s3_ff;
  logic       s1_busy, s1_done, s1_pass, s1_fv;
  logic       s3_busy, s3_done, s3_pass, s3_fv;
  logic [2:0] s1_err, s3_err;
  logic       s1_out, s3_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign s1_out = gt[s1_din];
  assign s3_out = gt[s3_din];

  gate_truth_checker #(.N_IN(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .truth(truth), .dut_out(s1_out),
    .dut_in(s1_din), .busy(s1_busy), .done(s1_done), .pass(s1_pass),
    .err_count(s1_err), .fail_valid(s1_fv), .first_fail(s1_ff)
  );

  gate_truth_checker #(.N_IN(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .truth(truth), .dut_out(s3_out),
    .dut_in(s3_din), .busy(s3_busy), .done(s3_done), .pass(s3_pass),
    .err_count(s3_err), .fail_valid(s3_fv), .first_fail(s3_ff)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] din;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err;
    logic       fv;
    logic [1:0] ff;
  } exp_t;

  bit       act1, act3;      // a run has been started since reset
  int       n1, n3;          // edges elapsed since the start edge
  bit [3:0] tq1, tq3;        // truth latched at start
  bit [3:0] gq1, gq3;        // gate table in force during the run
  logic     bm1, bm3;
  exp_t     e1, e3;

  assign bm1 = act1 && (n1 < 4);
  assign bm3 = act3 && (n3 < 12);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1 <= 1'b0; n1 <= 0; tq1 <= '0; gq1 <= '0;
      act3 <= 1'b0; n3 <= 0; tq3 <= '0; gq3 <= '0;
    end else begin
      if (start && !bm1) begin
        act1 <= 1'b1; n1 <= 0; tq1 <= truth; gq1 <= gt;
      end else if (act1 && n1 < 100) begin
        n1 <= n1 + 1;
      end
      if (start && !bm3) begin
        act3 <= 1'b1; n3 <= 0; tq3 <= truth; gq3 <= gt;
      end else if (act3 && n3 < 100) begin
        n3 <= n3 + 1;
      end
    end
  end

  // Combination k is sampled at edge SETTLE*(k+1); after n edges, n/SETTLE
  // combinations have been scored.
  function automatic exp_t expect_fn(int s, bit act, int n, bit [3:0] tq, bit [3:0] gq);
    exp_t     e;
    bit [3:0] mism;
    int       k;
    int       cnt;
    e = '0;
    if (!act) return e;
    if (n < s * 4) begin
      k      = n / s;
      e.din  = 2'(k);
      e.busy = 1'b1;
    end else begin
      k      = 4;
      e.done = 1'b1;
    end
    mism = tq ^ gq;
    cnt  = 0;
    for (int i = 0; i < k; i++) begin
      if (mism[i]) begin
        if (cnt == 0) e.ff = 2'(i);
        cnt++;
      end
    end
    e.err  = 3'(cnt);
    e.fv   = (cnt != 0);
    e.pass = e.done && (cnt == 0);
    return e;
  endfunction

  assign e1 = expect_fn(1, act1, n1, tq1, gq1);
  assign e3 = expect_fn(3, act3, n3, tq3, gq3);

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("s1.dut_in",     8'(s1_din),  8'(e1.din));
    chk("s1.busy",       8'(s1_busy), 8'(e1.busy));
    chk("s1.done",       8'(s1_done), 8'(e1.done));
    chk("s1.pass",       8'(s1_pass), 8'(e1.pass));
    chk("s1.err_count",  8'(s1_err),  8'(e1.err));
    chk("s1.fail_valid", 8'(s1_fv),   8'(e1.fv));
    chk("s1.first_fail", 8'(s1_ff),   8'(e1.ff));
    chk("s3.dut_in",     8'(s3_din),  8'(e3.din));
    chk("s3.busy",       8'(s3_busy), 8'(e3.busy));
    chk("s3.done",       8'(s3_done), 8'(e3.done));
    chk("s3.pass",       8'(s3_pass), 8'(e3.pass));
    chk("s3.err_count",  8'(s3_err),  8'(e3.err));
    chk("s3.fail_valid", 8'(s3_fv),   8'(e3.fv));
    chk("s3.first_fail", 8'(s3_ff),   8'(e3.ff));
  end

  // ---------------- stimulus helpers ----------------
  // Returns at the falling edge just after the start edge (0 edges elapsed).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!s1_busy && !s3_busy && !bm1 && !bm3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle t=%0t timed out busy s1=%0d s3=%0d", $time, s1_busy, s3_busy);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".s1.dut_in"}, 8'(s1_din), 8'd0);
    chk({tag, ".s1.busy"},   8'(s1_busy), 8'd0);
    chk({tag, ".s1.done"},   8'(s1_done), 8'd0);
    chk({tag, ".s1.err"},    8'(s1_err), 8'd0);
    chk({tag, ".s1.fv"},     8'(s1_fv), 8'd0);
    chk({tag, ".s3.dut_in"}, 8'(s3_din), 8'd0);
    chk({tag, ".s3.busy"},   8'(s3_busy), 8'd0);
    chk({tag, ".s3.err"},    8'(s3_err), 8'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Correct OR gate, SETTLE=1: dut_in 0..3 on consecutive cycles.
    gt = 4'b1110; truth = 4'b1110;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      chk("or.s1.dut_in", 8'(s1_din), 8'(k));
      chk("or.s1.done_early", 8'(s1_done), 8'd0);
      @(negedge clk);
    end
    chk("or.s1.done", 8'(s1_done), 8'd1);
    chk("or.s1.pass", 8'(s1_pass), 8'd1);
    chk("or.s1.err",  8'(s1_err), 8'd0);
    chk("or.s1.fv",   8'(s1_fv), 8'd0);
    wait_idle();

    // Stuck-at-0 gate.
    gt = 4'b0000;
    pulse_start();
    wait_idle();
    chk("sa0.s1.err",  8'(s1_err), 8'd3);
    chk("sa0.s1.ff",   8'(s1_ff), 8'd1);
    chk("sa0.s1.fv",   8'(s1_fv), 8'd1);
    chk("sa0.s1.pass", 8'(s1_pass), 8'd0);
    chk("sa0.s3.err",  8'(s3_err), 8'd3);

    // From a failing DONE, repair the gate and rerun: results clear at start.
    gt = 4'b1110;
    pulse_start();
    chk("rerun.s1.err",  8'(s1_err), 8'd0);
    chk("rerun.s1.fv",   8'(s1_fv), 8'd0);
    chk("rerun.s1.done", 8'(s1_done), 8'd0);
    wait_idle();
    chk("rerun.s1.pass", 8'(s1_pass), 8'd1);
    chk("rerun.s3.pass", 8'(s3_pass), 8'd1);

    // AND gate against OR truth table: mismatches at 1 and 2.
    gt = 4'b1000;
    pulse_start();
    wait_idle();
    chk("and.s1.err",  8'(s1_err), 8'd2);
    chk("and.s1.ff",   8'(s1_ff), 8'd1);
    chk("and.s1.pass", 8'(s1_pass), 8'd0);

    // SETTLE=3 timing; truth wiggle and a stray start mid-run are ignored.
    gt = 4'b1110;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      chk("s3.hold.dut_in", 8'(s3_din), 8'(k / 3));
      chk("s3.hold.done",   8'(s3_done), 8'd0);
      truth = (k == 2) ? 4'b0001 : 4'b1110;
      start = (k == 5);
      @(negedge clk);
    end
    start = 1'b0;
    truth = 4'b1110;
    chk("s3.done", 8'(s3_done), 8'd1);
    chk("s3.pass", 8'(s3_pass), 8'd1);
    wait_idle();

    // Reset two cycles into a run aborts at once.
    pulse_start();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    chk("post.s1.busy", 8'(s1_busy), 8'd1);
    wait_idle();
    chk("post.s1.pass", 8'(s1_pass), 8'd1);
    chk("post.s1.err",  8'(s1_err), 8'd0);
    chk("post.s3.pass", 8'(s3_pass), 8'd1);

    // Random gates, truth tables and stray starts.
    repeat (30) begin
      gt    = 4'($urandom);
      truth = 4'($urandom);
      pulse_start();
      for (int k = 0; k < 14; k++) begin
        truth = 4'($urandom);
        start = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
